// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port MEM_WB RAM (fetch read-only, data read/write).
// Optional build macro ARB_ROUND_ROBIN_EN: alternate ties instead of fixed data-over-fetch priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_nd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_rdy,
  output logic              busy,
  output logic              err_tmo
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 1 = data port owns the access
  logic              we_q, we_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              mem_nd_q, mem_nd_d;
  logic              mem_we_q, mem_we_d;
  logic              i_gnt_q, i_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              err_tmo_q, err_tmo_d;
  logic              pick_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_d_q, last_d_d;
`endif

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = d_req && (!i_req || !last_d_q);
`else
    pick_d = d_req;
`endif
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_nd_d   = 1'b0;
    mem_we_d   = 1'b0;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    i_valid_d  = 1'b0;
    d_valid_d  = 1'b0;
    err_tmo_d  = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d   = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          owner_d    = pick_d;
          we_d       = pick_d && d_we;
          mem_addr_d = pick_d ? d_addr : i_addr;
          if (pick_d) mem_din_d = d_wdata;
          d_gnt_d    = pick_d;
          i_gnt_d    = !pick_d;
          mem_we_d   = pick_d && d_we;
          mem_nd_d   = !(pick_d && d_we);
          state_d    = ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d   = pick_d;
`endif
        end
      end
      ISSUE: begin
        cnt_d   = 4'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (we_q || mem_rdy) begin
          // mem_dout is sampled only for a read that has seen rdy
          if (!we_q) begin
            if (owner_q) d_rdata_d = mem_dout;
            else         i_rdata_d = mem_dout;
          end
          d_valid_d = owner_q;
          i_valid_d = !owner_q;
          state_d   = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          err_tmo_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= 4'd0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_nd_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_valid_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
      err_tmo_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_nd_q   <= mem_nd_d;
      mem_we_q   <= mem_we_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      i_valid_q  <= i_valid_d;
      d_valid_q  <= d_valid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      busy_q     <= busy_d;
      err_tmo_q  <= err_tmo_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q   <= last_d_d;
`endif
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_nd   = mem_nd_q;
  assign mem_we   = mem_we_q;
  assign i_gnt    = i_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign i_valid  = i_valid_q;
  assign d_valid  = d_valid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = busy_q;
  assign err_tmo  = err_tmo_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RAM and a completion scoreboard.
module tb_mem_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          i_gnt, d_gnt, i_valid, d_valid, mem_nd, mem_we, busy, err_tmo;
  logic [DW-1:0] i_rdata, d_rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic          mem_rdy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic          owner;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_nd(mem_nd), .mem_we(mem_we),
    .mem_dout(mem_dout), .mem_rdy(mem_rdy), .busy(busy), .err_tmo(err_tmo)
  );

  // RAM model: one-cycle read latency, dout floats unless rdy
  logic [DW-1:0] ram [0:2047];
  logic [DW-1:0] dout_r = '0;
  logic          rdy_r = 1'b0;
  bit            rdy_en = 1'b1;
  assign mem_rdy  = rdy_r;
  assign mem_dout = rdy_r ? dout_r : 'z;

  always @(posedge clk) begin
    rdy_r <= 1'b0;
    if (mem_we) ram[mem_addr] <= mem_din;
    if (mem_nd && rdy_en) begin
      rdy_r  <= 1'b1;
      dout_r <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input logic owner, input logic [DW-1:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      chk("unexpected_valid", {31'd0, owner}, 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      chk("sb_owner", {31'd0, owner}, {31'd0, e.owner});
      chk("sb_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (i_valid) sb_pop(1'b0, i_rdata);
      if (d_valid) sb_pop(1'b1, d_rdata);
    end
  end

  initial begin
    int c;
    int last_c;
    bit got;
    logic exp_order [4];
    for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
    ram[11'h010] = 32'hDEADBEEF;

    // reset values
    #12;
    chk("rst_ctrl", {20'd0, i_gnt, d_gnt, i_valid, d_valid, mem_nd, mem_we, busy, err_tmo}, 32'd0);
    chk("rst_addr", {21'd0, mem_addr}, 32'd0);
    chk("rst_din", mem_din, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // fetch read
    i_req = 1'b1; i_addr = 11'h010;
    sb.push_back('{1'b0, 32'hDEADBEEF});
    @(negedge clk);
    chk("f_c1_gnt", {30'd0, i_gnt, d_gnt}, 32'd2);
    chk("f_c1_nd", {30'd0, mem_nd, mem_we}, 32'd2);
    chk("f_c1_addr", {21'd0, mem_addr}, 32'h010);
    i_req = 1'b0;
    @(negedge clk);
    chk("f_c2_nd_busy", {30'd0, mem_nd, busy}, 32'd1);
    @(negedge clk);
    chk("f_c3_valid", {31'd0, i_valid}, 32'd1);
    @(negedge clk);
    chk("f_c4_idle", {30'd0, i_valid, busy}, 32'd0);

    // data write; read bus is Z during writes, d_rdata must hold 0
    d_req = 1'b1; d_we = 1'b1; d_addr = 11'h7FF; d_wdata = 32'h12345678;
    sb.push_back('{1'b1, 32'h0});
    @(negedge clk);
    chk("w_c1_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
    chk("w_c1_we", {30'd0, mem_nd, mem_we}, 32'd1);
    chk("w_c1_din", mem_din, 32'h12345678);
    d_req = 1'b0;
    @(negedge clk);
    chk("w_c2_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("w_c3_valid", {31'd0, d_valid}, 32'd1);
    chk("w_ram", ram[11'h7FF], 32'h12345678);

    // data read back
    d_req = 1'b1; d_we = 1'b0;
    sb.push_back('{1'b1, 32'h12345678});
    @(negedge clk); d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("r_c3_valid", {31'd0, d_valid}, 32'd1);
    @(negedge clk);

    // timeout: no rdy during a fetch read
    rdy_en = 1'b0;
    i_req = 1'b1; i_addr = 11'h020;
    c = 0; got = 0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 1) i_req = 1'b0;
      if (err_tmo) got = 1;
    end
    chk("tmo_cycle", c, 32'd17);
    chk("tmo_busy_valid", {30'd0, busy, i_valid}, 32'd0);
    @(negedge clk);
    chk("tmo_after", {29'd0, err_tmo, busy, i_valid}, 32'd0);
    rdy_en = 1'b1;

    // reset during ISSUE
    i_req = 1'b1; i_addr = 11'h010;
    @(negedge clk);
    chk("ra_issue", {31'd0, mem_nd}, 32'd1);
    i_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ra_outs", {24'd0, i_gnt, d_gnt, i_valid, d_valid, mem_nd, mem_we, busy, err_tmo}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("ra_idle", {31'd0, busy}, 32'd0);

    // both requests held for four accesses
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    i_req = 1'b1; i_addr = 11'h010;
    d_req = 1'b1; d_we = 1'b0; d_addr = 11'h7FF;
    c = 0; last_c = 0;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      while (!got && c < last_c + 10) begin
        @(negedge clk);
        c++;
        if (i_gnt && d_gnt) chk("tie_both_gnt", 32'd1, 32'd0);
        if (i_gnt || d_gnt) got = 1;
      end
      if (!got) begin
        chk("tie_gnt_timeout", k, 32'hFFFF_FFFF);
        break;
      end
      chk("tie_owner", {31'd0, d_gnt}, {31'd0, exp_order[k]});
      if (k > 0) chk("tie_gap", c - last_c, 32'd3);
      last_c = c;
      sb.push_back('{d_gnt, d_gnt ? 32'h12345678 : 32'hDEADBEEF});
      if (k == 3) begin i_req = 1'b0; d_req = 1'b0; end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
